// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encodings, default 12 MHz timing constants and sizing helpers
// for the SB_PLL40 lock sequencer.
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_RESET_HOLD_CYCLES   = 12;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 12000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1200;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_LOCK_SYNC_STAGES    = 2;

  function automatic int pll_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Never returns 0 so that degenerate parameter sets still give a legal vector.
  function automatic int pll_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_bit_synchronizer.sv
// Async-reset flop chain for bringing an asynchronous status bit into the
// local clock domain.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw bit through the chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the video PLL in reset, waits for a stable LOCK, then releases the
// video pipeline; re-sequences on lock loss or timeout with bounded retries.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int LOCK_SYNC_STAGES    = DEF_LOCK_SYNC_STAGES
) (
  input  logic                                  REFERENCECLK,
  input  logic                                  RESET,
  input  logic                                  pll_lock,
  input  logic                                  restart_req,
  output logic                                  pll_resetb,
  output logic                                  video_rst_n,
  output logic                                  ready,
  output logic                                  fault,
  output logic                                  lock_lost,
  output logic [pll_width(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [2:0]                            state_o
);

  localparam int CNT_W   = pll_width(pll_max3(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                              LOCK_STABLE_CYCLES));
  localparam int RETRY_W = pll_width(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST_C    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST_C = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST_C  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT_C      = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_MAX_C    = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_r;
  pll_state_e         next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [RETRY_W-1:0] retry_r;
  logic [RETRY_W-1:0] retry_next_s;
  logic               lost_next_s;
  logic               cnt_clear_s;
  logic               lock_s;

  bit_synchronizer #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state decision; restart_req overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    retry_next_s = retry_r;
    lost_next_s  = 1'b0;
    if (restart_req) begin
      next_state_s = ST_HOLD;
      retry_next_s = {RETRY_W{1'b0}};
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST_C) begin
            next_state_s = ST_WAIT_LOCK;
          end else begin
            next_state_s = ST_HOLD;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            next_state_s = ST_STABLE;
          end else if (cnt_r == TIMEOUT_LAST_C) begin
            if (retry_r == RETRY_MAX_C) begin
              next_state_s = ST_FAULT;
            end else begin
              next_state_s = ST_HOLD;
              retry_next_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
            end
          end else begin
            next_state_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // A lock drop while qualifying counts as a failed attempt.
          if (!lock_s) begin
            if (retry_r == RETRY_MAX_C) begin
              next_state_s = ST_FAULT;
            end else begin
              next_state_s = ST_HOLD;
              retry_next_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
            end
          end else if (cnt_r == STABLE_LAST_C) begin
            next_state_s = ST_RUN;
            retry_next_s = {RETRY_W{1'b0}};
          end else begin
            next_state_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            next_state_s = ST_HOLD;
            retry_next_s = {RETRY_W{1'b0}};
            lost_next_s  = 1'b1;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          next_state_s = ST_FAULT;
        end
        default: begin
          next_state_s = ST_HOLD;
          retry_next_s = {RETRY_W{1'b0}};
        end
      endcase
    end
  end

  assign cnt_clear_s = restart_req || (next_state_s != state_r);

  // State, counter, retry count and Moore outputs decoded from the next state.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= ST_HOLD;
      cnt_r       <= {CNT_W{1'b0}};
      retry_r     <= {RETRY_W{1'b0}};
      pll_resetb  <= 1'b0;
      video_rst_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (cnt_clear_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_SAT_C) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      retry_r     <= retry_next_s;
      pll_resetb  <= (next_state_s == ST_WAIT_LOCK) || (next_state_s == ST_STABLE) ||
                     (next_state_s == ST_RUN);
      video_rst_n <= (next_state_s == ST_RUN);
      ready       <= (next_state_s == ST_RUN);
      fault       <= (next_state_s == ST_FAULT);
      lock_lost   <= lost_next_s;
    end
  end

  assign retry_count = retry_r;
  assign state_o     = state_r;

endmodule
